// File: rtl/data_memory_block.sv
// Block-organised data memory with a fixed access latency.
// A read or write request is captured in IDLE, held for LATENCY-1 edges in
// BUSY, committed on the last of them, and reported for one DONE cycle.
// busywait_o is combinational so the requester sees the stall in the same
// cycle it raises a request.
//
// Build option: define DMEM_RESET_CLEAR_EN to have reset also clear every
// storage entry to zero; otherwise storage survives reset and powers up
// undefined.
//
// state | meaning
// IDLE  | waiting for read_i/write_i; request captured on the next edge
// BUSY  | access in flight; counter runs up to LATENCY-1, then commit
// DONE  | single completion cycle; busywait_o low, readdata_o valid

module data_memory_block #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 5
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         read_i,
   input  logic         write_i,
   input  logic [27:0]  address_i,
   input  logic [127:0] writedata_i,
   output logic [127:0] readdata_o,
   output logic         busywait_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [AW-1:0]  idx_q;
   logic [127:0]   wdata_q;
   logic           op_wr_q;
   logic [127:0]   rdata_q;
   logic [127:0]   mem_q [DEPTH];

   logic           req;
   logic           commit_d;
   logic           mem_wr_d;
   logic           unused_addr;

   assign req         = read_i | write_i;
   assign commit_d    = (state_q == BUSY) && (cnt_q == CW'(LATENCY - 1));
   assign mem_wr_d    = commit_d & op_wr_q;
   // Upper address bits alias onto the same entries by design.
   assign unused_addr = ^address_i;

   assign busywait_o  = req && (state_q != DONE);
   assign readdata_o  = rdata_q;

   // Access sequencer: capture, count, commit and registered read data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         op_wr_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  state_q <= BUSY;
                  cnt_q   <= CW'(1);
                  idx_q   <= address_i[AW-1:0];
                  wdata_q <= writedata_i;
                  // Read and write together is a write.
                  op_wr_q <= write_i;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q + CW'(1);
               if (commit_d) begin
                  state_q <= DONE;
                  if (!op_wr_q) begin
                     rdata_q <= mem_q[idx_q];
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

`ifdef DMEM_RESET_CLEAR_EN
   // Storage array, cleared to zero by reset; written on write commit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_wr_d) begin
         mem_q[idx_q] <= wdata_q;
      end
   end
`else
   // Storage array, retained across reset; written on write commit.
   // A reset mid-access returns the sequencer to IDLE, so no commit follows.
   always_ff @(posedge clk_i) begin
      if (mem_wr_d) begin
         mem_q[idx_q] <= wdata_q;
      end
   end
`endif

endmodule

// File: tb/tb_data_memory_block.sv
// Testbench for data_memory_block: directed corner cases followed by random
// traffic, checked through an expected-value queue and an output monitor.

module tb_data_memory_block;

   localparam int DEPTH = 256;
   localparam int LAT   = 5;

   logic         clk_i       = 1'b0;
   logic         rst_i       = 1'b1;
   logic         read_i      = 1'b0;
   logic         write_i     = 1'b0;
   logic [27:0]  address_i   = '0;
   logic [127:0] writedata_i = '0;
   logic [127:0] readdata_o;
   logic         busywait_o;

   int total = 0;
   int bad   = 0;

   logic [127:0] exp_q [$];
   logic [127:0] mem_m [DEPTH];
   bit           known [DEPTH];
   logic [127:0] last_rd = '0;

   data_memory_block #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .read_i      (read_i),
      .write_i     (write_i),
      .address_i   (address_i),
      .writedata_i (writedata_i),
      .readdata_o  (readdata_o),
      .busywait_o  (busywait_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Model reset: read data returns to zero; storage cleared only when built so.
   task automatic model_reset();
      last_rd = '0;
`ifdef DMEM_RESET_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) begin
         mem_m[i] = '0;
         known[i] = 1'b1;
      end
`endif
   endtask

   // Monitor: a completion is a cycle with a request present and no stall.
   always @(negedge clk_i) begin
      if (!rst_i && (read_i || write_i) && !busywait_o) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_completion actual=%h required=none", readdata_o);
         end else begin
            check("readdata", readdata_o, exp_q.pop_front());
         end
      end
   end

   // Issue one access starting just after a rising edge; returns just after
   // the rising edge that ends the completion cycle.
   task automatic do_access(input bit rd, input bit wr, input logic [27:0] addr,
                            input logic [127:0] data, input bit hold, input bit scramble);
      int idx;
      int n;
      idx = int'(addr) % DEPTH;
      if (wr) begin
         mem_m[idx] = data;
         known[idx] = 1'b1;
         exp_q.push_back(last_rd);
      end else begin
         last_rd = mem_m[idx];
         exp_q.push_back(last_rd);
      end
      read_i      = rd;
      write_i     = wr;
      address_i   = addr;
      writedata_i = data;
      n = 0;
      for (int k = 0; k < 4 * LAT; k++) begin
         @(negedge clk_i);
         if (!busywait_o) break;
         n++;
         if (scramble) begin
            @(posedge clk_i);
            #1;
            {read_i, write_i} = 2'($urandom_range(1, 3));
            address_i   = 28'($urandom);
            writedata_i = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      check("latency", 128'(n), 128'(LAT));
      @(posedge clk_i);
      #1;
      if (!hold) begin
         read_i  = 1'b0;
         write_i = 1'b0;
      end
   endtask

   localparam logic [127:0] D30 = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] A5  = {64{2'b10}};
   localparam logic [127:0] P5  = {64{2'b01}};

   logic [27:0]  r_addr;
   logic [127:0] r_data;
   logic [127:0] prev_pat;
   int           r_idx;
   int           r_op;
   int           r_gap;
   bit           r_rd;
   bit           r_wr;
   bit           r_hold;
   bit           r_scr;

   initial begin
      model_reset();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_busywait", 128'(busywait_o), 128'(0));
      check("reset_readdata", readdata_o, '0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Read of a cleared (or freshly zeroed) entry.
      if (!known[3]) do_access(1'b0, 1'b1, 28'h3, '0, 1'b0, 1'b0);
      do_access(1'b1, 1'b0, 28'h0000003, '0, 1'b0, 1'b0);

      // Write then read back.
      do_access(1'b0, 1'b1, 28'h0000010, D30, 1'b0, 1'b0);
      do_access(1'b1, 1'b0, 28'h0000010, '0, 1'b0, 1'b0);

      // Aliasing of upper address bits.
      do_access(1'b0, 1'b1, 28'h0000105, ONES, 1'b0, 1'b0);
      do_access(1'b1, 1'b0, 28'h0000005, '0, 1'b0, 1'b0);

      // Read and write together behave as a write.
      do_access(1'b1, 1'b1, 28'h0000007, P5, 1'b0, 1'b0);
      do_access(1'b1, 1'b0, 28'h0000007, '0, 1'b0, 1'b0);

      // Request held through DONE: back-to-back accesses.
      do_access(1'b1, 1'b0, 28'h0000010, '0, 1'b1, 1'b0);
      do_access(1'b1, 1'b0, 28'h0000105, '0, 1'b0, 1'b0);

      // Request dropped right after acceptance still completes.
      read_i    = 1'b1;
      address_i = 28'h0000010;
      @(posedge clk_i);
      #1;
      read_i = 1'b0;
      @(negedge clk_i);
      check("dropped_busywait", 128'(busywait_o), 128'(0));
      repeat (3) @(negedge clk_i);
      check("dropped_before_commit", readdata_o, ONES);
      @(negedge clk_i);
      check("dropped_commit", readdata_o, D30);
      last_rd = D30;
      @(posedge clk_i);
      #1;

      // Reset during BUSY aborts a pending write.
      do_access(1'b0, 1'b1, 28'h0000020, D30, 1'b0, 1'b0);
      prev_pat    = mem_m[32];
      write_i     = 1'b1;
      address_i   = 28'h0000020;
      writedata_i = A5;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      check("rst_busywait_req", 128'(busywait_o), 128'(1));
      check("rst_readdata", readdata_o, '0);
      @(posedge clk_i);
      #1;
      write_i = 1'b0;
      @(negedge clk_i);
      check("rst_busywait_noreq", 128'(busywait_o), 128'(0));
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      model_reset();
      mem_m[32] = prev_pat;
`ifdef DMEM_RESET_CLEAR_EN
      mem_m[32] = '0;
`endif
      do_access(1'b1, 1'b0, 28'h0000020, '0, 1'b0, 1'b0);

      // Random traffic.
      for (int t = 0; t < 150; t++) begin
         r_addr = 28'($urandom);
         r_data = {$urandom, $urandom, $urandom, $urandom};
         r_idx  = int'(r_addr) % DEPTH;
         r_op   = $urandom_range(0, 2);
         r_rd   = (r_op != 1);
         r_wr   = (r_op != 0);
         if (r_rd && !r_wr && !known[r_idx]) begin
            r_rd = 1'b0;
            r_wr = 1'b1;
         end
         r_hold = ($urandom_range(0, 3) == 0) && (t < 149);
         r_scr  = ($urandom_range(0, 1) == 1);
         do_access(r_rd, r_wr, r_addr, r_data, r_hold, r_scr);
         if (!r_hold) begin
            r_gap = $urandom_range(0, 2);
            for (int g = 0; g < r_gap; g++) begin
               @(posedge clk_i);
               #1;
            end
         end
      end

      repeat (2) @(posedge clk_i);
      check("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_memory_block.md
DATA_MEMORY_BLOCK -- requirements
Module: data_memory

Interface
REQ-001 Parameter: DEPTH, default 256, number of 128-bit blocks stored (power of two, 2..2^28).
REQ-002 Parameter: LATENCY, default 5, clock cycles from request acceptance to completion (>=2).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 READ  input  1  block read request, held high until BUSYWAIT is low.
REQ-006 WRITE  input  1  block write request, held high until BUSYWAIT is low.
REQ-007 ADDRESS  input  28  block address; index = ADDRESS[log2(DEPTH)-1:0]; upper bits ignored (aliasing).
REQ-008 WRITEDATA  input  128  block to write.
REQ-009 READDATA  output  128  registered block read data.
REQ-010 BUSYWAIT  output  1  stall to requester while an access is pending.

Function
REQ-011 Storage SHALL be DEPTH entries of 128 bits, whole-block access only, no byte enables.
REQ-012 State machine SHALL have states IDLE, BUSY, DONE.
REQ-013 IDLE: READ or WRITE high at rising edge -> BUSY; ADDRESS, WRITEDATA and operation captured; cycle counter set to 1.
REQ-014 BUSY: counter increments each edge; at the edge where counter equals LATENCY-1 the access commits and state -> DONE.
REQ-015 Commit of a read SHALL load READDATA with the captured-index entry; commit of a write SHALL store the captured WRITEDATA, READDATA unchanged.
REQ-016 DONE SHALL last exactly one cycle, then -> IDLE unconditionally.
REQ-017 BUSYWAIT SHALL be combinational: (READ or WRITE) and state != DONE; low whenever no request is present.
REQ-018 Net latency: request raised in cycle 0 -> BUSYWAIT low in cycle LATENCY, READDATA valid in that same cycle.
REQ-019 READ and WRITE both high SHALL be treated as a write.
REQ-020 Changes to ADDRESS/WRITEDATA/READ/WRITE during BUSY SHALL be ignored; the captured request completes.
REQ-021 Request still high in the DONE cycle SHALL start a new access at the first edge in IDLE (back-to-back accesses allowed, one idle cycle minimum).
REQ-022 Request dropped during BUSY SHALL not abort the access; it completes, BUSYWAIT already low.
REQ-023 READDATA SHALL hold its last value until the next read commit or reset.

Reset
REQ-024 RESET high SHALL immediately force state IDLE, counter 0, READDATA 0, independent of CLK.
REQ-025 Access in progress at reset SHALL be aborted; a pending write SHALL not be stored.
REQ-026 While RESET is high no request SHALL be accepted; BUSYWAIT follows REQ-017 (high if request present).

Configuration
REQ-027 Macro DMEM_RESET_CLEAR_EN: when defined, reset SHALL also clear every storage entry to 0.
REQ-028 Without DMEM_RESET_CLEAR_EN, storage contents SHALL survive reset and power up undefined (X in simulation).

Verification
REQ-029 Reset (macro defined), READ addr 0x0000003 -> BUSYWAIT high cycles 0-4, low cycle 5, READDATA = 0.
REQ-030 WRITE addr 0x0000010 data 0x0123456789ABCDEF_FEDCBA9876543210, then READ same addr -> READDATA equals written value in completion cycle.
REQ-031 WRITE addr 0x0000105 data all-ones, READ addr 0x0000005 (DEPTH 256) -> READDATA all-ones (aliasing).
REQ-032 WRITE addr 0x20 data 0xAA.., assert RESET in BUSY cycle 2, then READ 0x20 -> no write stored (0 with macro, prior contents without).
REQ-033 READ+WRITE together addr 0x7 data 0x55.. -> treated as write, READDATA unchanged; subsequent READ 0x7 returns 0x55...
REQ-034 Request held through DONE -> second access starts, BUSYWAIT high cycle LATENCY+1, low cycle 2*LATENCY+1.
